// File: rtl/slv_pkg.sv
// Shared types for the write-slot monitor: the write FSM state encoding, the phase counter
// indices, and the per-state mask of counters under timeout check.
package slv_pkg;

   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      WRITE_ADDRESS  = 2'd1,
      WRITE_DATA     = 2'd2,
      WRITE_RESPONSE = 2'd3
   } write_state_e;

   localparam int unsigned NumCnt = 6;

   localparam int unsigned IdxAwvalidAwready   = 0;
   localparam int unsigned IdxAwvalidWfirst    = 1;
   localparam int unsigned IdxWvalidWreadyFrst = 2;
   localparam int unsigned IdxWfirstWlast      = 3;
   localparam int unsigned IdxWlastBvalid      = 4;
   localparam int unsigned IdxBvalidBready     = 5;

   typedef logic [NumCnt-1:0] cnt_mask_t;

   // Only the counters of the phase currently in flight can expire.
   function automatic cnt_mask_t state_check_mask(input write_state_e st);
      cnt_mask_t m;
      m = '0;
      unique case (st)
         WRITE_ADDRESS: begin
            m[IdxAwvalidAwready] = 1'b1;
            m[IdxAwvalidWfirst]  = 1'b1;
         end
         WRITE_DATA: begin
            m[IdxWvalidWreadyFrst] = 1'b1;
            m[IdxWfirstWlast]      = 1'b1;
         end
         WRITE_RESPONSE: begin
            m[IdxWlastBvalid]  = 1'b1;
            m[IdxBvalidBready] = 1'b1;
         end
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/wr_budget_cmp.sv
// Budget comparators: flags counters of the current phase that reached their non-zero budget.
// Latency: combinational, lowest expired index wins; backpressure: none.
module wr_budget_cmp
   import slv_pkg::*;
#(
   parameter int unsigned CntWidth = 8
) (
   input  write_state_e                     state_i,
   input  logic [NumCnt-1:0][CntWidth-1:0]  cnt_i,
   input  logic [NumCnt-1:0][CntWidth-1:0]  budget_i,
   output logic                             exp_vld_o,
   output logic [2:0]                       exp_idx_o
);

   cnt_mask_t mask;
   cnt_mask_t expired;

   always_comb begin
      mask    = state_check_mask(state_i);
      expired = '0;
      for (int k = 0; k < NumCnt; k++) begin
         expired[k] = mask[k] && (budget_i[k] != '0) && (cnt_i[k] >= budget_i[k]);
      end
   end

   // Scan downward so the lowest expired index is the last one written.
   always_comb begin
      exp_idx_o = '0;
      for (int k = NumCnt - 1; k >= 0; k--) begin
         if (expired[k]) begin
            exp_idx_o = 3'(k);
         end
      end
   end

   assign exp_vld_o = |expired;

endmodule

// File: rtl/wr_slot_tracker.sv
// Tracks one outstanding AXI write through AW/W/B phases and flags phase timeouts.
// Latency: state and status 1 cycle, cnt_clr_o same cycle; backpressure: none, observe only.
module wr_slot_tracker
   import slv_pkg::*;
#(
   parameter int unsigned CntWidth = 8,
   parameter int unsigned IdWidth  = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             alloc_i,
   input  logic [IdWidth-1:0]               aw_id_i,
   input  logic                             abort_i,
   input  logic                             w_sel_i,
   input  logic                             w_valid_i,
   input  logic                             w_ready_i,
   input  logic                             w_last_i,
   input  logic                             b_valid_i,
   input  logic                             b_ready_i,
   input  logic [IdWidth-1:0]               b_id_i,
   input  logic [NumCnt-1:0][CntWidth-1:0]  cnt_i,
   input  logic [NumCnt-1:0][CntWidth-1:0]  budget_i,
   output logic                             free_o,
   output write_state_e                     state_o,
   output logic [IdWidth-1:0]               id_o,
   output logic                             cnt_clr_o,
   output logic                             timeout_o,
   output logic [2:0]                       timeout_idx_o,
   output logic                             irq_o,
   output logic                             done_o,
   output logic                             alloc_err_o
);

   write_state_e state_q, state_d;
   logic [IdWidth-1:0] id_q;
   logic timeout_q, irq_q, done_q, alloc_err_q;
   logic [2:0] timeout_idx_q;

   logic w_beat, w_last_hs, b_hs_match;
   logic alloc_ok, b_done;
   logic exp_vld;
   logic [2:0] exp_idx;

   assign w_beat     = w_sel_i & w_valid_i;
   assign w_last_hs  = w_beat & w_ready_i & w_last_i;
   assign b_hs_match = b_valid_i & b_ready_i & (b_id_i == id_q);

   always_comb begin
      state_d  = state_q;
      alloc_ok = 1'b0;
      b_done   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (alloc_i) begin
               state_d  = WRITE_ADDRESS;
               alloc_ok = 1'b1;
            end
         end
         WRITE_ADDRESS: begin
            if (w_last_hs) begin
               state_d = WRITE_RESPONSE;
            end else if (w_beat) begin
               state_d = WRITE_DATA;
            end
         end
         WRITE_DATA: begin
            if (w_last_hs) begin
               state_d = WRITE_RESPONSE;
            end
         end
         WRITE_RESPONSE: begin
            if (b_hs_match) begin
               state_d = IDLE;
               b_done  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort wins over every other event, including a coincident allocation.
      if (abort_i) begin
         state_d  = IDLE;
         alloc_ok = 1'b0;
         b_done   = 1'b0;
      end
   end

   wr_budget_cmp #(
      .CntWidth (CntWidth)
   ) u_budget_cmp (
      .state_i   (state_q),
      .cnt_i     (cnt_i),
      .budget_i  (budget_i),
      .exp_vld_o (exp_vld),
      .exp_idx_o (exp_idx)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         id_q          <= '0;
         timeout_q     <= 1'b0;
         timeout_idx_q <= '0;
         irq_q         <= 1'b0;
         done_q        <= 1'b0;
         alloc_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= b_done;
         alloc_err_q <= alloc_i & ~alloc_ok;
         irq_q       <= 1'b0;
         if (alloc_ok) begin
            id_q <= aw_id_i;
         end
         // A slot heading back to IDLE drops its timeout status and raises no interrupt.
         if (state_d == IDLE) begin
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
         end else if (!timeout_q && exp_vld) begin
            timeout_q     <= 1'b1;
            timeout_idx_q <= exp_idx;
            irq_q         <= 1'b1;
         end
      end
   end

   assign free_o        = (state_q == IDLE);
   assign state_o       = state_q;
   assign id_o          = id_q;
   assign cnt_clr_o     = alloc_ok;
   assign timeout_o     = timeout_q;
   assign timeout_idx_o = timeout_idx_q;
   assign irq_o         = irq_q;
   assign done_o        = done_q;
   assign alloc_err_o   = alloc_err_q;

endmodule

// File: tb/tb_wr_slot_tracker.sv
// Directed bench for wr_slot_tracker: walks the write FSM, timeouts, abort and reset.
module tb_wr_slot_tracker;
   import slv_pkg::*;

   localparam int unsigned CW = 8;
   localparam int unsigned IW = 4;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic alloc_i, abort_i, w_sel_i, w_valid_i, w_ready_i, w_last_i;
   logic b_valid_i, b_ready_i;
   logic [IW-1:0] aw_id_i, b_id_i;
   logic [NumCnt-1:0][CW-1:0] cnt_i, budget_i;
   logic free_o, cnt_clr_o, timeout_o, irq_o, done_o, alloc_err_o;
   write_state_e state_o;
   logic [IW-1:0] id_o;
   logic [2:0] timeout_idx_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_i = ~clk_i;

   wr_slot_tracker #(
      .CntWidth (CW),
      .IdWidth  (IW)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .alloc_i       (alloc_i),
      .aw_id_i       (aw_id_i),
      .abort_i       (abort_i),
      .w_sel_i       (w_sel_i),
      .w_valid_i     (w_valid_i),
      .w_ready_i     (w_ready_i),
      .w_last_i      (w_last_i),
      .b_valid_i     (b_valid_i),
      .b_ready_i     (b_ready_i),
      .b_id_i        (b_id_i),
      .cnt_i         (cnt_i),
      .budget_i      (budget_i),
      .free_o        (free_o),
      .state_o       (state_o),
      .id_o          (id_o),
      .cnt_clr_o     (cnt_clr_o),
      .timeout_o     (timeout_o),
      .timeout_idx_o (timeout_idx_o),
      .irq_o         (irq_o),
      .done_o        (done_o),
      .alloc_err_o   (alloc_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; registered outputs are stable on return.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_i   = 1'b0;
      aw_id_i   = '0;
      abort_i   = 1'b0;
      w_sel_i   = 1'b0;
      w_valid_i = 1'b0;
      w_ready_i = 1'b0;
      w_last_i  = 1'b0;
      b_valid_i = 1'b0;
      b_ready_i = 1'b0;
      b_id_i    = '0;
   endtask

   task automatic w_beat(input logic last);
      w_sel_i   = 1'b1;
      w_valid_i = 1'b1;
      w_ready_i = 1'b1;
      w_last_i  = last;
      cyc();
      w_sel_i   = 1'b0;
      w_valid_i = 1'b0;
      w_ready_i = 1'b0;
      w_last_i  = 1'b0;
   endtask

   task automatic b_resp(input logic [IW-1:0] id);
      b_valid_i = 1'b1;
      b_ready_i = 1'b1;
      b_id_i    = id;
      cyc();
      b_valid_i = 1'b0;
      b_ready_i = 1'b0;
   endtask

   task automatic do_alloc(input logic [IW-1:0] id);
      alloc_i = 1'b1;
      aw_id_i = id;
      cyc();
      alloc_i = 1'b0;
   endtask

   initial begin
      idle_inputs();
      cnt_i    = '0;
      budget_i = '0;
      rst_ni   = 1'b0;
      #3;
      chk("rst_state", state_o, IDLE);
      chk("rst_free", free_o, 1);
      chk("rst_id", id_o, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("rst_idx", timeout_idx_o, 0);
      chk("rst_pulses", {irq_o, done_o, alloc_err_o, cnt_clr_o}, 0);
      cyc();
      cyc();
      rst_ni = 1'b1;
      cyc();

      // Full transaction, multi-beat W
      alloc_i = 1'b1;
      aw_id_i = 4'd3;
      #1;
      chk("clr_at_alloc", cnt_clr_o, 1);
      cyc();
      alloc_i = 1'b0;
      #1;
      chk("t1_addr", state_o, WRITE_ADDRESS);
      chk("t1_id", id_o, 3);
      chk("t1_not_free", free_o, 0);
      chk("t1_clr_once", cnt_clr_o, 0);
      w_beat(1'b0);
      chk("t1_data", state_o, WRITE_DATA);
      w_beat(1'b1);
      chk("t1_resp", state_o, WRITE_RESPONSE);
      b_resp(4'd3);
      chk("t1_idle", state_o, IDLE);
      chk("t1_done", done_o, 1);
      chk("t1_free", free_o, 1);
      cyc();
      chk("t1_done_once", done_o, 0);

      // Single-beat W skips WRITE_DATA
      do_alloc(4'd5);
      chk("t2_addr", state_o, WRITE_ADDRESS);
      w_beat(1'b1);
      chk("t2_skip_data", state_o, WRITE_RESPONSE);
      b_resp(4'd5);
      chk("t2_idle", state_o, IDLE);

      // Timeout in WRITE_DATA on index 3; index 0 expired too but masked
      do_alloc(4'd3);
      w_beat(1'b0);
      chk("t3_data", state_o, WRITE_DATA);
      b_resp(4'd3);
      chk("t3_b_ignored", state_o, WRITE_DATA);
      budget_i[3] = 8'd5;
      budget_i[0] = 8'd1;
      cnt_i[0]    = 8'd9;
      for (int c = 0; c < 10; c++) begin
         cnt_i[3] = 8'(c);
         cyc();
         chk($sformatf("t3_to_c%0d", c), timeout_o, (c >= 5) ? 1 : 0);
         chk($sformatf("t3_irq_c%0d", c), irq_o, (c == 5) ? 1 : 0);
         if (c >= 5) chk($sformatf("t3_idx_c%0d", c), timeout_idx_o, 3);
      end
      w_beat(1'b1);
      chk("t3_resp", state_o, WRITE_RESPONSE);
      chk("t3_to_held", timeout_o, 1);
      b_resp(4'd2);
      chk("t3_wrong_id", state_o, WRITE_RESPONSE);
      chk("t3_no_done", done_o, 0);
      b_resp(4'd3);
      chk("t3_idle", state_o, IDLE);
      chk("t3_to_clr", timeout_o, 0);
      chk("t3_done", done_o, 1);
      cnt_i    = '0;
      budget_i = '0;

      // Alloc while busy, then abort with timeout pending
      do_alloc(4'd3);
      w_beat(1'b0);
      chk("t4_data", state_o, WRITE_DATA);
      alloc_i = 1'b1;
      aw_id_i = 4'd9;
      #1;
      chk("t4_no_clr", cnt_clr_o, 0);
      cyc();
      alloc_i = 1'b0;
      chk("t4_alloc_err", alloc_err_o, 1);
      chk("t4_id_kept", id_o, 3);
      chk("t4_state_kept", state_o, WRITE_DATA);
      budget_i[2] = 8'd4;
      cnt_i[2]    = 8'd4;
      cyc();
      chk("t4_err_once", alloc_err_o, 0);
      chk("t4_to", timeout_o, 1);
      chk("t4_idx", timeout_idx_o, 2);
      chk("t4_irq", irq_o, 1);
      abort_i = 1'b1;
      cyc();
      abort_i = 1'b0;
      chk("t4_abort_idle", state_o, IDLE);
      chk("t4_abort_to", timeout_o, 0);
      chk("t4_abort_pulses", {done_o, irq_o}, 0);
      cnt_i    = '0;
      budget_i = '0;

      // Asynchronous reset mid-transaction
      do_alloc(4'd7);
      w_beat(1'b1);
      chk("t5_resp", state_o, WRITE_RESPONSE);
      budget_i[4] = 8'd1;
      cnt_i[4]    = 8'd1;
      cyc();
      chk("t5_to", timeout_o, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("t5_rst_state", state_o, IDLE);
      chk("t5_rst_free", free_o, 1);
      chk("t5_rst_id", id_o, 0);
      chk("t5_rst_to", {timeout_o, timeout_idx_o}, 0);
      chk("t5_rst_pulses", {irq_o, done_o, alloc_err_o}, 0);
      cyc();
      rst_ni = 1'b1;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
